// File: rtl/cdc_sync_bank.sv
// cdc_sync_bank: multi-flop bus synchronizer with optional per-bit stability filter,
// edge pulses and, in GRAY mode, pointer decode plus multi-bit jump detection.
module cdc_sync_bank #(
    parameter int WIDTH  = 9,
    parameter int STAGES = 2,
    parameter int MODE   = 0,
    parameter int FILTER = 0,
    parameter int ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_sync,
    output logic [WIDTH-1:0] d_bin,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed,
    output logic             gray_err,
    output logic [ERR_W-1:0] err_cnt
);
    generate
        if (STAGES < 2 || STAGES > 8) begin : g_bad_stages
            $error("cdc_sync_bank: STAGES must be 2..8");
        end
        if (FILTER > 15) begin : g_bad_filter
            $error("cdc_sync_bank: FILTER must be 0..15");
        end
        if (FILTER != 0 && MODE == 1) begin : g_bad_mode
            $error("cdc_sync_bank: FILTER is only allowed in LEVEL mode");
        end
    endgenerate

    logic [WIDTH-1:0] s [STAGES];
    logic [WIDTH-1:0] s_last;
    logic [WIDTH-1:0] prev;

    // Plain flop chain: nothing may sit between stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) s[i] <= '0;
        end else begin
            s[0] <= d_in;
            for (int i = 1; i < STAGES; i++) s[i] <= s[i-1];
        end
    end

    assign s_last = s[STAGES-1];

    generate
        if (FILTER == 0) begin : g_nofilt
            assign d_sync = s_last;
        end else begin : g_filt
            logic [3:0] cnt [WIDTH];
            // A bit only follows s_last after FILTER consecutive mismatching cycles.
            always_ff @(posedge clk) begin
                for (int b = 0; b < WIDTH; b++) begin
                    if (rst) begin
                        cnt[b]    <= '0;
                        d_sync[b] <= 1'b0;
                    end else if (s_last[b] == d_sync[b]) begin
                        cnt[b] <= '0;
                    end else if (cnt[b] == 4'(FILTER - 1)) begin
                        d_sync[b] <= s_last[b];
                        cnt[b]    <= '0;
                    end else begin
                        cnt[b] <= cnt[b] + 4'd1;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) prev <= rst ? '0 : d_sync;

    assign rise    = d_sync & ~prev;
    assign fall    = ~d_sync & prev;
    assign changed = |(rise | fall);

    generate
        if (MODE == 1) begin : g_gray
            logic [WIDTH-1:0] diff;
            for (genvar i = 0; i < WIDTH; i++) begin : g_bin
                assign d_bin[i] = ^(d_sync >> i);
            end
            assign diff = d_sync ^ prev;
            // More than one bit set iff clearing the lowest set bit leaves something.
            assign gray_err = |(diff & (diff - WIDTH'(1)));
            always_ff @(posedge clk) begin
                if (rst) err_cnt <= '0;
                else if (gray_err && err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
            end
        end else begin : g_level
            assign d_bin    = d_sync;
            assign gray_err = 1'b0;
            assign err_cnt  = '0;
        end
    endgenerate
endmodule

// File: tb/tb_cdc_sync_bank.sv
// tb_cdc_sync_bank: randomized and directed checks of three cdc_sync_bank configurations
// against a history-based behavioural model.
module tb_cdc_sync_bank;
    localparam int W    = 9;
    localparam int MAXE = 8000;
    localparam int SL   = 3;
    localparam int SF   = 2;
    localparam int SG   = 2;
    localparam int F    = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [W-1:0] din_l = '0, din_f = '0, din_g = '0;
    logic [W-1:0] ds_l, db_l, ri_l, fa_l, ds_f, db_f, ri_f, fa_f, ds_g, db_g, ri_g, fa_g;
    logic ch_l, ge_l, ch_f, ge_f, ch_g, ge_g;
    logic [7:0] ec_l, ec_f, ec_g;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cdc_sync_bank #(.WIDTH(W), .STAGES(SL), .MODE(0), .FILTER(0), .ERR_W(8)) u_lvl (
        .clk(clk), .rst(rst), .d_in(din_l), .d_sync(ds_l), .d_bin(db_l), .rise(ri_l),
        .fall(fa_l), .changed(ch_l), .gray_err(ge_l), .err_cnt(ec_l));
    cdc_sync_bank #(.WIDTH(W), .STAGES(SF), .MODE(0), .FILTER(F), .ERR_W(8)) u_flt (
        .clk(clk), .rst(rst), .d_in(din_f), .d_sync(ds_f), .d_bin(db_f), .rise(ri_f),
        .fall(fa_f), .changed(ch_f), .gray_err(ge_f), .err_cnt(ec_f));
    cdc_sync_bank #(.WIDTH(W), .STAGES(SG), .MODE(1), .FILTER(0), .ERR_W(8)) u_gry (
        .clk(clk), .rst(rst), .d_in(din_g), .d_sync(ds_g), .d_bin(db_g), .rise(ri_g),
        .fall(fa_g), .changed(ch_g), .gray_err(ge_g), .err_cnt(ec_g));

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Per-edge history of what each DUT sampled, and whether that edge was a reset edge.
    logic [W-1:0] din_h [3][MAXE];
    bit           rst_h [MAXE];
    logic [W-1:0] xs_h  [MAXE];
    logic [W-1:0] ds_h  [3][MAXE];

    // Chain output after edge n: the value sampled s-1 edges earlier, unless a reset intervened.
    function automatic logic [W-1:0] sync_raw(input int k, input int n, input int s);
        int m;
        m = n - s + 1;
        if (m < 0) return '0;
        for (int j = m; j <= n; j++) if (rst_h[j]) return '0;
        return din_h[k][m];
    endfunction

    function automatic logic [W-1:0] b2g(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
        logic [W-1:0] b;
        b = g;
        for (int i = 1; i < W; i++) b = b ^ (g >> i);
        return b;
    endfunction

    // Model and compare process: runs on every falling edge.
    initial begin
        int n;
        logic [W-1:0] ds, pv, dbx;
        logic [7:0] ecnt;
        bit gprev, ge, okr, all;
        logic v;
        logic [45:0] got, exp;
        string nm;
        n = 0; ecnt = '0; gprev = 1'b0;
        for (int k = 0; k < 3; k++) din_h[k][0] = '0;
        rst_h[0] = 1'b1;
        forever begin
            @(negedge clk);
            if (n >= MAXE - 1) begin
                $display("FAIL cycle_budget: got %0d edges, limit %0d", n, MAXE - 1);
                $fatal(1, "edge budget exhausted");
            end
            for (int k = 0; k < 3; k++) begin
                if (k == 1) begin
                    xs_h[n] = sync_raw(1, n, SF);
                    if (rst_h[n]) ds = '0;
                    else begin
                        ds = ds_h[1][n-1];
                        okr = (n >= F);
                        for (int j = n - F + 1; j <= n; j++) if (j >= 0 && rst_h[j]) okr = 1'b0;
                        if (okr) for (int b = 0; b < W; b++) begin
                            v = xs_h[n-1][b];
                            all = 1'b1;
                            for (int j = 2; j <= F; j++) if (xs_h[n-j][b] != v) all = 1'b0;
                            if (all) ds[b] = v;
                        end
                    end
                end else ds = sync_raw(k, n, k == 0 ? SL : SG);
                ds_h[k][n] = ds;
                pv = (rst_h[n] || n == 0) ? '0 : ds_h[k][n-1];
                ge = 1'b0;
                dbx = ds;
                if (k == 2) begin
                    if (rst_h[n]) ecnt = '0;
                    else if (gprev && ecnt != 8'hFF) ecnt = ecnt + 8'd1;
                    ge = $countones(ds ^ pv) > 1;
                    gprev = ge;
                    dbx = g2b(ds);
                end
                exp = {ds, dbx, ds & ~pv, ~ds & pv, |(ds ^ pv), ge, k == 2 ? ecnt : 8'h00};
                if (k == 0) begin nm = "model_lvl"; got = {ds_l, db_l, ri_l, fa_l, ch_l, ge_l, ec_l}; end
                else if (k == 1) begin nm = "model_flt"; got = {ds_f, db_f, ri_f, fa_f, ch_f, ge_f, ec_f}; end
                else begin nm = "model_gry"; got = {ds_g, db_g, ri_g, fa_g, ch_g, ge_g, ec_g}; end
                chk(nm, 64'(got), 64'(exp));
            end
            din_h[0][n+1] = din_l;
            din_h[1][n+1] = din_f;
            din_h[2][n+1] = din_g;
            rst_h[n+1]    = rst;
            n++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] gval;
        int r;
        repeat (3) step();
        chk("reset_dsync", 64'(ds_l), 64'h0);
        chk("reset_errcnt", 64'(ec_g), 64'h0);
        chk("reset_pulses", 64'({ri_g, fa_g, ch_g, ge_g}), 64'h0);
        rst = 1'b0;
        repeat (4) step();

        // Latency with STAGES=3
        din_l = 9'h055;
        repeat (2) step();
        chk("lat_before", 64'(ds_l), 64'h0);
        step();
        chk("lat_dsync", 64'(ds_l), 64'h055);
        chk("lat_rise", 64'(ri_l), 64'h055);
        chk("lat_changed", 64'(ch_l), 64'h1);
        step();
        chk("lat_rise_once", 64'({ri_l, ch_l}), 64'h0);

        // Fall pattern
        din_l = 9'h0FF;
        repeat (5) step();
        din_l = 9'h0F0;
        repeat (3) step();
        chk("fall_bits", 64'(fa_l), 64'h00F);
        chk("fall_norise", 64'(ri_l), 64'h0);
        step();
        chk("fall_once", 64'({fa_l, ch_l}), 64'h0);
        repeat (3) step();
        chk("hold_quiet", 64'(ch_l), 64'h0);

        // Filter: 2-cycle glitch is rejected, 3-cycle pulse passes after STAGES+F edges
        din_f = 9'h001;
        repeat (2) step();
        din_f = 9'h000;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("flt_glitch", 64'({ds_f, ch_f}), 64'h0);
        end
        din_f = 9'h001;
        repeat (3) step();
        din_f = 9'h000;
        step();
        chk("flt_not_yet", 64'(ds_f), 64'h0);
        step();
        chk("flt_rise_dsync", 64'(ds_f), 64'h001);
        chk("flt_rise_pulse", 64'(ri_f), 64'h001);
        repeat (10) step();

        // Gray walk 0..511 and wrap to 0
        for (int i = 0; i <= 512; i++) begin
            gval = W'(i);
            din_g = b2g(gval);
            repeat (4) step();
            chk("gray_walk_bin", 64'({db_g, ge_g}), 64'({gval, 1'b0}));
        end
        chk("gray_wrap_errcnt", 64'(ec_g), 64'h0);

        // Gray jumps and saturation
        din_g = 9'h003;
        repeat (2) step();
        chk("gray_jump_err", 64'(ge_g), 64'h1);
        step();
        chk("gray_jump_once", 64'(ge_g), 64'h0);
        chk("gray_jump_cnt", 64'(ec_g), 64'h1);
        for (int j = 0; j < 299; j++) begin
            din_g = din_g ^ 9'h003;
            repeat (3) step();
            if (j == 99) chk("gray_cnt_101", 64'(ec_g), 64'd101);
        end
        repeat (3) step();
        chk("gray_saturate", 64'(ec_g), 64'd255);

        // Reset mid-operation
        din_l = 9'h1A5;
        step();
        rst = 1'b1;
        step();
        chk("midrst_dsync", 64'({ds_l, ds_f, ds_g}), 64'h0);
        chk("midrst_pulses", 64'({ri_l, fa_l, ch_l, ge_g}), 64'h0);
        chk("midrst_errcnt", 64'(ec_g), 64'h0);
        rst = 1'b0;
        repeat (2) step();
        chk("postrst_wait", 64'(ds_l), 64'h0);
        step();
        chk("postrst_dsync", 64'(ds_l), 64'h1A5);

        // Randomized traffic; the model process checks every cycle
        gval = g2b(din_g);
        for (int i = 0; i < 2500; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3) == 0) din_l = W'($urandom);
            din_f = din_f ^ W'($urandom & $urandom & $urandom);
            r = $urandom_range(0, 15);
            if (r == 0) gval = W'($urandom);
            else if (r < 8) gval = gval + W'(1);
            else if (r < 13) gval = gval - W'(1);
            din_g = b2g(gval);
            step();
        end
        rst = 1'b0;
        repeat (10) step();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
